pipelined_decode: RTL
=====================

Name: pipelined_decode

Overview:
- Next-generation decode stage for the pipelined LEGv8 core.
- Parametrised in data width and register count; owns the register file, the opcode decode and the ID/EX pipeline register.
- Adds load-use hazard detection, bubble insertion, a multiplier start/done handshake FSM and optional write-back bypass.
- Sits between the IF/ID register and the execute stage.

Parameters:
- WORD, 64, datapath and register width.
- NUM_REGS, 32, register count; index NUM_REGS-1 is XZR.
- LINK_REG, 30, destination register for BL.
- REG_ADDR_W, $clog2(NUM_REGS), register index width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- instr_valid  in  1  IF/ID holds a real instruction.
- instruction  in  `INSTR_LEN  IF/ID instruction.
- stall_in  in  1  downstream freeze; ID/EX register holds.
- multiplier_done  in  1  multiplier result ready.
- wb_reg_write  in  1  write-back enable.
- wb_write_reg  in  REG_ADDR_W  write-back index.
- wb_write_data  in  WORD  write-back data.
- stall_out  out  1  hold PC and IF/ID this cycle.
- mult_start  out  1  one-cycle multiplier start pulse.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_opcode  out  11  registered opcode.
- ex_read_data1, ex_read_data2  out  WORD  registered operands.
- ex_imm  out  WORD  registered sign-extended immediate.
- ex_rd  out  REG_ADDR_W  registered destination (LINK_REG for BL).
- ex_ctrl  out  `CTRL_W  registered control bundle (mem_read, mem_write, alu_src, reg_write, update_sreg, execute_result_loc, branch_op, mem_to_reg, mult_mode, alu_op).

Behaviour:
- Reset: all ex_* outputs 0, ex_valid=0, stall_out=0, mult_start=0, FSM=RUN, all registers 0. Reset asserted mid-multiply aborts to RUN with no pulse.
- Register file: read is combinational; write is on the clock edge when wb_reg_write=1. Writes to XZR are ignored and XZR always reads 0.
- Second read index = rd for STUR/CBZ/CBNZ, else rm.
- Load-use hazard (hz): ex_valid & ex_ctrl.mem_read & ex_rd!=XZR & (ex_rd==rn | ex_rd==read_reg2), evaluated only when instr_valid.
  - hz=1 -> stall_out=1 and the ID/EX register loads a bubble (all zero). Latency: exactly 1 bubble per load-use pair.
- stall_in has priority over everything:
  - ID/EX holds.
  - stall_out=1.
  - FSM does not advance.
  - No mult_start.
- FSM states: RUN and MULT_WAIT.
  - RUN: a valid MUL/UMULH/SMULH with no hz and no stall_in -> mult_start=1 for exactly that cycle, the instruction loads into ID/EX, go to MULT_WAIT.
  - MULT_WAIT: stall_out=1 and ID/EX loads bubbles. When multiplier_done=1 -> RUN; the next instruction is decoded in the following cycle.
  - multiplier_done while in RUN is ignored.
- Otherwise ID/EX loads the decoded instruction with ex_valid=instr_valid.
- ex_imm uses the existing sign_extender rules. Arithmetic is width-generic to WORD.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: a read index equal to wb_write_reg while wb_reg_write=1 (not XZR) returns wb_write_data in the same cycle.
- Undefined: the read returns the stale register value. The hazard unit additionally raises stall_out for 1 cycle on that match and loads a bubble; it re-reads after the write lands.

Decomposition:
- Shared constants header: `INSTR_LEN, `CTRL_W, ex_ctrl field offsets, opcode constants for MUL/UMULH/SMULH/LDUR/STUR/CBZ/CBNZ/BL.
- Sub-module decode_regfile (parametrised WORD/NUM_REGS, async reset, XZR rule, bypass under the macro).
- Opcode decode and sign extension reuse the existing control and sign_extender modules.

Test Plan:
- Reset while in MULT_WAIT -> next cycle ex_valid=0, stall_out=0, FSM=RUN, registers read 0.
- wb writes X5=0x1234, then ADD X1,X5,X5 -> ex_read_data1=ex_read_data2=0x1234. Without macro, same-cycle write plus read -> 1 bubble, then 0x1234.
- LDUR X2,[X3] followed by ADD X4,X2,X1 -> stall_out=1 for 1 cycle, one bubble (ex_valid=0), ADD enters ID/EX the next cycle.
- MUL X6,X7,X8 with done after 4 cycles -> mult_start high 1 cycle, stall_out high 4 cycles, next instruction decoded on cycle 5.
- Write 0xFFFF to X31, then read X31 -> 0. LDUR into XZR followed by use -> no stall.
- stall_in held 3 cycles with valid ADD in IF/ID -> ID/EX unchanged, no mult_start, ADD enters after release.

Source files
------------

// File: rtl/pipelined_decode_pkg.sv
// Shared decode constants: instruction/control widths, ex_ctrl layout, LEGv8 opcodes and
// the control/sign-extension helpers used by pipelined_decode.
`ifndef PIPELINED_DECODE_DEFS
`define PIPELINED_DECODE_DEFS
`define INSTR_LEN 32
`define CTRL_W 13
`endif

package pipelined_decode_pkg;

  // ex_ctrl bit offsets (LSB of each field)
  localparam int CTRL_ALU_OP     = 0;
  localparam int CTRL_MULT_MODE  = 2;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_BRANCH_OP  = 5;
  localparam int CTRL_EXEC_LOC   = 7;
  localparam int CTRL_UPD_SREG   = 8;
  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_ALU_SRC    = 10;
  localparam int CTRL_MEM_WRITE  = 11;
  localparam int CTRL_MEM_READ   = 12;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_ADDI  = 11'b1001000100?;
  localparam logic [10:0] OP_SUBI  = 11'b1101000100?;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100???;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101???;
  localparam logic [10:0] OP_B     = 11'b000101?????;
  localparam logic [10:0] OP_BL    = 11'b100101?????;
  localparam logic [10:0] OP_MUL   = 11'b10011011000;
  localparam logic [10:0] OP_UMULH = 11'b10011011110;
  localparam logic [10:0] OP_SMULH = 11'b10011011010;

  typedef enum logic {ST_RUN, ST_MULT_WAIT} state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       update_sreg;
    logic       execute_result_loc;  // 1: result comes from the multiplier
    logic [1:0] branch_op;           // 0 none, 1 uncond, 2 cbz, 3 cbnz
    logic       mem_to_reg;
    logic [1:0] mult_mode;           // 0 MUL, 1 UMULH, 2 SMULH
    logic [1:0] alu_op;              // 0 add, 1 sub, 2 and, 3 orr
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [10:0] op);
    ctrl_t c;
    c = '0;
    casez (op)
      OP_ADD:   c.reg_write = 1'b1;
      OP_ADDS:  begin c.reg_write = 1'b1; c.update_sreg = 1'b1; end
      OP_SUB:   begin c.reg_write = 1'b1; c.alu_op = 2'd1; end
      OP_SUBS:  begin c.reg_write = 1'b1; c.alu_op = 2'd1; c.update_sreg = 1'b1; end
      OP_AND:   begin c.reg_write = 1'b1; c.alu_op = 2'd2; end
      OP_ORR:   begin c.reg_write = 1'b1; c.alu_op = 2'd3; end
      OP_ADDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      OP_SUBI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = 2'd1; end
      OP_LDUR:  begin c.mem_read = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      OP_STUR:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      OP_CBZ:   c.branch_op = 2'd2;
      OP_CBNZ:  c.branch_op = 2'd3;
      OP_B:     c.branch_op = 2'd1;
      OP_BL:    begin c.branch_op = 2'd1; c.reg_write = 1'b1; end
      OP_MUL:   begin c.reg_write = 1'b1; c.execute_result_loc = 1'b1; end
      OP_UMULH: begin c.reg_write = 1'b1; c.execute_result_loc = 1'b1; c.mult_mode = 2'd1; end
      OP_SMULH: begin c.reg_write = 1'b1; c.execute_result_loc = 1'b1; c.mult_mode = 2'd2; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_mult(input logic [10:0] op);
    return (op == OP_MUL) || (op == OP_UMULH) || (op == OP_SMULH);
  endfunction

  function automatic logic reads_rt(input logic [10:0] op);
    casez (op)
      OP_STUR, OP_CBZ, OP_CBNZ: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_bl(input logic [10:0] op);
    casez (op)
      OP_BL:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Immediate sign-extended to 26 bits; the caller widens it to the datapath.
  function automatic logic [25:0] imm26(input logic [`INSTR_LEN-1:0] instr);
    casez (instr[31:21])
      OP_LDUR, OP_STUR: return {{17{instr[20]}}, instr[20:12]};
      OP_ADDI, OP_SUBI: return {{14{instr[21]}}, instr[21:10]};
      OP_CBZ, OP_CBNZ:  return {{7{instr[23]}}, instr[23:5]};
      OP_B, OP_BL:      return instr[25:0];
      default:          return '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file with combinational reads, clocked writes and a hard-wired zero register.
// Build option DECODE_WB_BYPASS_EN forwards the write-back data to a matching read.
module decode_regfile
  import pipelined_decode_pkg::*;
#(
  parameter int WORD     = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [WORD-1:0]   read_data1,
  output logic [WORD-1:0]   read_data2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [WORD-1:0]   write_data
);

  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NUM_REGS - 1);

  logic [WORD-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_en && write_reg != XZR) begin
      regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data1 = (read_reg1 == XZR) ? '0 : regs[read_reg1];
    read_data2 = (read_reg2 == XZR) ? '0 : regs[read_reg2];
`ifdef DECODE_WB_BYPASS_EN
    if (write_en && write_reg != XZR) begin
      if (write_reg == read_reg1) read_data1 = write_data;
      if (write_reg == read_reg2) read_data2 = write_data;
    end
`endif
  end

endmodule

// File: rtl/pipelined_decode.sv
// LEGv8 decode stage: register file, control decode, load-use/write-back hazards, multiplier FSM
// and the ID/EX register. Optional same-cycle write-back bypass via DECODE_WB_BYPASS_EN.
module pipelined_decode
  import pipelined_decode_pkg::*;
#(
  parameter int WORD       = 64,
  parameter int NUM_REGS   = 32,
  parameter int LINK_REG   = 30,
  parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [`INSTR_LEN-1:0] instruction,
  input  logic                  stall_in,
  input  logic                  multiplier_done,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [WORD-1:0]       wb_write_data,
  output logic                  stall_out,
  output logic                  mult_start,
  output logic                  ex_valid,
  output logic [10:0]           ex_opcode,
  output logic [WORD-1:0]       ex_read_data1,
  output logic [WORD-1:0]       ex_read_data2,
  output logic [WORD-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [`CTRL_W-1:0]    ex_ctrl
);

  localparam logic [REG_ADDR_W-1:0] XZR = REG_ADDR_W'(NUM_REGS - 1);

  logic [10:0]           opcode;
  logic [REG_ADDR_W-1:0] rn, rm, rd, read_reg2, rd_d;
  logic [WORD-1:0]       read_data1, read_data2, imm_d;
  logic [25:0]           imm_s;
  ctrl_t                 ctrl_d, ex_ctrl_q;
  logic                  hz_load, hz_wb, hz, go_mult;
  logic                  idex_en, idex_bubble;
  state_t                state, state_nxt;

  assign opcode    = instruction[31:21];
  assign rm        = REG_ADDR_W'(instruction[20:16]);
  assign rn        = REG_ADDR_W'(instruction[9:5]);
  assign rd        = REG_ADDR_W'(instruction[4:0]);
  assign read_reg2 = reads_rt(opcode) ? rd : rm;
  assign rd_d      = is_bl(opcode) ? REG_ADDR_W'(LINK_REG) : rd;
  assign ctrl_d    = decode_ctrl(opcode);
  assign imm_s     = imm26(instruction);
  assign imm_d     = {{(WORD-26){imm_s[25]}}, imm_s};
  assign ex_ctrl   = ex_ctrl_q;

  decode_regfile #(.WORD(WORD), .NUM_REGS(NUM_REGS), .ADDR_W(REG_ADDR_W)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (rn),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_en   (wb_reg_write),
    .write_reg  (wb_write_reg),
    .write_data (wb_write_data)
  );

  assign hz_load = instr_valid && ex_valid && ex_ctrl_q.mem_read && (ex_rd != XZR) &&
                   ((ex_rd == rn) || (ex_rd == read_reg2));
`ifdef DECODE_WB_BYPASS_EN
  assign hz_wb = 1'b0;
`else
  // Without forwarding the read would see the stale value; wait one cycle for the write to land.
  assign hz_wb = instr_valid && wb_reg_write && (wb_write_reg != XZR) &&
                 ((wb_write_reg == rn) || (wb_write_reg == read_reg2));
`endif
  assign hz      = hz_load || hz_wb;
  assign go_mult = instr_valid && !hz && is_mult(opcode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!stall_in) begin
      case (state)
        ST_RUN:       if (go_mult) state_nxt = ST_MULT_WAIT;
        ST_MULT_WAIT: if (multiplier_done) state_nxt = ST_RUN;
        default:      state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_out   = 1'b0;
    mult_start  = 1'b0;
    idex_en     = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      stall_out = 1'b0;
    end else if (stall_in) begin
      stall_out = 1'b1;
    end else if (state == ST_MULT_WAIT || hz) begin
      stall_out   = 1'b1;
      idex_en     = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      idex_en    = 1'b1;
      mult_start = go_mult;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_opcode     <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm        <= '0;
      ex_rd         <= '0;
      ex_ctrl_q     <= '0;
    end else if (idex_en) begin
      if (idex_bubble) begin
        ex_valid      <= 1'b0;
        ex_opcode     <= '0;
        ex_read_data1 <= '0;
        ex_read_data2 <= '0;
        ex_imm        <= '0;
        ex_rd         <= '0;
        ex_ctrl_q     <= '0;
      end else begin
        ex_valid      <= instr_valid;
        ex_opcode     <= opcode;
        ex_read_data1 <= read_data1;
        ex_read_data2 <= read_data2;
        ex_imm        <= imm_d;
        ex_rd         <= rd_d;
        ex_ctrl_q     <= ctrl_d;
      end
    end
  end

endmodule
